// File: rtl/scb_arbiter_if.sv
// Bus bundle between two SCB requesters, the arbiter and the scratchpad port.
// The arbiter connects through the slave modport; the requesters and memory use master.
interface scb_arbiter_if #(
  parameter int unsigned A = 11,
  parameter int unsigned D = 16,
  parameter int unsigned B = 2
);
  logic [A-1:0] m0_Addr_i, m1_Addr_i;
  logic [D-1:0] m0_Data_i, m1_Data_i;
  logic [B-1:0] m0_stb_i, m1_stb_i;
  logic         m0_ce_i, m1_ce_i;
  logic         m0_rd_i, m1_rd_i;
  logic         m0_wr_i, m1_wr_i;
  logic [D-1:0] m0_Data_o, m1_Data_o;
  logic         m0_ack_o, m1_ack_o;
  logic         m0_err_o, m1_err_o;
  logic [A-1:0] scb_Addr_o;
  logic [D-1:0] scb_Data_o;
  logic [B-1:0] scb_stb_o;
  logic         scb_ce_o, scb_rd_o, scb_wr_o;
  logic [D-1:0] scb_Data_i;
  logic         scb_rdy_i;

  modport slave (
    input  m0_Addr_i, m1_Addr_i, m0_Data_i, m1_Data_i, m0_stb_i, m1_stb_i,
    input  m0_ce_i, m1_ce_i, m0_rd_i, m1_rd_i, m0_wr_i, m1_wr_i,
    output m0_Data_o, m1_Data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    input  scb_Data_i, scb_rdy_i
  );

  modport master (
    output m0_Addr_i, m1_Addr_i, m0_Data_i, m1_Data_i, m0_stb_i, m1_stb_i,
    output m0_ce_i, m1_ce_i, m0_rd_i, m1_rd_i, m0_wr_i, m1_wr_i,
    input  m0_Data_o, m1_Data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    output scb_Data_i, scb_rdy_i
  );
endinterface

// File: rtl/scb_arbiter.sv
// Two-requester arbiter for the SCB scratchpad: combinational grant, one-cycle registered ack,
// round-robin or fixed priority, and rejection of malformed commands without touching memory.
module scb_arbiter #(
  parameter int unsigned A         = 11,
  parameter int unsigned D         = 16,
  parameter int unsigned B         = 2,
  parameter bit          FIXED_PRI = 1'b0
) (
  input logic          clk_i,
  input logic          rst_i,
  scb_arbiter_if.slave bus
);

  logic         w_ack0, w_ack1;
  logic         w_elig0, w_elig1;
  logic         w_gnt, w_any, w_ill, w_legal, w_accept;
  logic [A-1:0] w_addr;
  logic [D-1:0] w_data;
  logic [B-1:0] w_stb;
  logic         w_rd, w_wr;

  logic r_last_gnt;
  logic r_lock, r_lock_id;
  logic r_rsp_vld, r_rsp_id, r_rsp_err;

  assign w_ack0 = r_rsp_vld & ~r_rsp_id;
  assign w_ack1 = r_rsp_vld & r_rsp_id;

  // A requester whose ack is high this cycle is completing, not asking again.
  assign w_elig0 = bus.m0_ce_i & ~w_ack0;
  assign w_elig1 = bus.m1_ce_i & ~w_ack1;

  always_comb begin
    w_gnt = 1'b0;
    if (r_lock) begin
      w_gnt = r_lock_id;
    end else if (w_elig0 && w_elig1) begin
      w_gnt = FIXED_PRI ? 1'b0 : ~r_last_gnt;
    end else begin
      w_gnt = ~w_elig0 & w_elig1;
    end
  end

  assign w_any  = ~rst_i & (w_gnt ? w_elig1 : w_elig0);
  assign w_addr = w_gnt ? bus.m1_Addr_i : bus.m0_Addr_i;
  assign w_data = w_gnt ? bus.m1_Data_i : bus.m0_Data_i;
  assign w_stb  = w_gnt ? bus.m1_stb_i  : bus.m0_stb_i;
  assign w_rd   = w_gnt ? bus.m1_rd_i   : bus.m0_rd_i;
  assign w_wr   = w_gnt ? bus.m1_wr_i   : bus.m0_wr_i;

  assign w_ill    = (w_rd == w_wr) || (w_stb == '0);
  assign w_legal  = w_any & ~w_ill;
  assign w_accept = w_any & bus.scb_rdy_i;

  assign bus.scb_ce_o   = w_legal;
  assign bus.scb_rd_o   = w_legal & w_rd;
  assign bus.scb_wr_o   = w_legal & w_wr;
  assign bus.scb_stb_o  = w_legal ? w_stb : '0;
  assign bus.scb_Addr_o = w_any ? w_addr : '0;
  assign bus.scb_Data_o = w_any ? w_data : '0;

  assign bus.m0_ack_o  = w_ack0;
  assign bus.m1_ack_o  = w_ack1;
  assign bus.m0_err_o  = w_ack0 & r_rsp_err;
  assign bus.m1_err_o  = w_ack1 & r_rsp_err;
  assign bus.m0_Data_o = (w_ack0 && !r_rsp_err) ? bus.scb_Data_i : '0;
  assign bus.m1_Data_o = (w_ack1 && !r_rsp_err) ? bus.scb_Data_i : '0;

  // A stalled issue locks the grant so a late arrival cannot steal the port mid-stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_gnt <= 1'b1;
      r_lock     <= 1'b0;
      r_lock_id  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_rsp_vld <= w_accept;
      r_rsp_id  <= w_gnt;
      r_rsp_err <= w_ill;
      r_lock    <= w_any & ~bus.scb_rdy_i;
      r_lock_id <= w_gnt;
      if (w_accept) begin
        r_last_gnt <= w_gnt;
      end
    end
  end

endmodule

// File: tb/tb_scb_arbiter.sv
// Bench for scb_arbiter: directed scenarios plus randomized per-master transactions checked
// against a word-level memory model.
module tb_scb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  scb_arbiter_if #(.A(11), .D(16), .B(2)) bus ();
  scb_arbiter_if #(.A(11), .D(16), .B(2)) bus_f ();

  scb_arbiter #(.A(11), .D(16), .B(2), .FIXED_PRI(1'b0)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  scb_arbiter #(.A(11), .D(16), .B(2), .FIXED_PRI(1'b1)) u_dut_fix (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_f)
  );

  assign bus_f.m0_Addr_i  = bus.m0_Addr_i;
  assign bus_f.m1_Addr_i  = bus.m1_Addr_i;
  assign bus_f.m0_Data_i  = bus.m0_Data_i;
  assign bus_f.m1_Data_i  = bus.m1_Data_i;
  assign bus_f.m0_stb_i   = bus.m0_stb_i;
  assign bus_f.m1_stb_i   = bus.m1_stb_i;
  assign bus_f.m0_ce_i    = bus.m0_ce_i;
  assign bus_f.m1_ce_i    = bus.m1_ce_i;
  assign bus_f.m0_rd_i    = bus.m0_rd_i;
  assign bus_f.m1_rd_i    = bus.m1_rd_i;
  assign bus_f.m0_wr_i    = bus.m0_wr_i;
  assign bus_f.m1_wr_i    = bus.m1_wr_i;
  assign bus_f.scb_rdy_i  = bus.scb_rdy_i;
  assign bus_f.scb_Data_i = bus.scb_Data_i;

  // Scratchpad model: 1024 words, read data valid the cycle after issue.
  logic [15:0] mem [1024];
  logic [15:0] rdata;
  logic        pre_w = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  assign bus.scb_Data_i = rdata;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (pre_w) mem[pre_a] <= pre_d;
      if (bus.scb_ce_o && bus.scb_rdy_i) begin
        if (bus.scb_wr_o) begin
          if (bus.scb_stb_o[0]) mem[bus.scb_Addr_o[10:1]][7:0]  <= bus.scb_Data_o[7:0];
          if (bus.scb_stb_o[1]) mem[bus.scb_Addr_o[10:1]][15:8] <= bus.scb_Data_o[15:8];
        end
        if (bus.scb_rd_o) rdata <= mem[bus.scb_Addr_o[10:1]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_w = 1'b1;
    nxt();
    pre_w = 1'b0;
  endtask

  task automatic drive(input int m, input logic [10:0] a, input logic [15:0] d,
                       input logic [1:0] s, input logic rd, input logic wr, input logic ce);
    if (m == 0) begin
      bus.m0_Addr_i = a; bus.m0_Data_i = d; bus.m0_stb_i = s;
      bus.m0_rd_i = rd; bus.m0_wr_i = wr; bus.m0_ce_i = ce;
    end else begin
      bus.m1_Addr_i = a; bus.m1_Data_i = d; bus.m1_stb_i = s;
      bus.m1_rd_i = rd; bus.m1_wr_i = wr; bus.m1_ce_i = ce;
    end
  endtask

  // Issues one request, holds it until ack (bounded), then releases ce.
  task automatic do_txn(input int m, input logic [10:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic rd, input logic wr,
                        output logic [15:0] rdat, output logic err);
    bit seen = 0;
    rdat = '0; err = 1'b0;
    drive(m, a, d, s, rd, wr, 1'b1);
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (m == 0 && bus.m0_ack_o) begin
        seen = 1; rdat = bus.m0_Data_o; err = bus.m0_err_o;
      end else if (m == 1 && bus.m1_ack_o) begin
        seen = 1; rdat = bus.m1_Data_o; err = bus.m1_err_o;
      end
    end
    if (!seen) check("ack_timeout", 32'(m), 32'hFF);
    nxt();
    drive(m, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  logic [15:0] mdl [1024];
  bit          chk_legal = 0;
  bit          done0 = 0, done1 = 0;

  always @(negedge clk) begin
    if (chk_legal && bus.scb_ce_o)
      check("scb_legal", {30'd0, bus.scb_rd_o != bus.scb_wr_o, bus.scb_stb_o != 2'b00}, 32'd3);
  end

  task automatic rand_txn(input int m);
    logic [10:0] a;
    logic [15:0] d, rdat;
    logic [1:0]  s;
    logic        rd, wr, err, ill;
    int          kind;
    repeat ($urandom_range(0, 2)) nxt();
    a    = {m[0], 5'd0, 4'($urandom_range(0, 15)), 1'b0};
    d    = 16'($urandom);
    s    = 2'($urandom_range(1, 3));
    kind = $urandom_range(0, 9);
    rd   = (kind >= 5);
    wr   = (kind >= 1 && kind <= 4);
    if (kind == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        rd = 1'($urandom_range(0, 1)); wr = rd;
      end else begin
        rd = 1'b1; wr = 1'b0; s = 2'b00;
      end
    end
    ill = (rd == wr) || (s == 2'b00);
    do_txn(m, a, d, s, rd, wr, rdat, err);
    check(m == 0 ? "r_err0" : "r_err1", {31'd0, err}, {31'd0, ill});
    if (!ill && wr) begin
      if (s[0]) mdl[a[10:1]][7:0]  = d[7:0];
      if (s[1]) mdl[a[10:1]][15:8] = d[15:8];
    end
    if (!ill && rd) check(m == 0 ? "r_rdat0" : "r_rdat1", {16'd0, rdat}, {16'd0, mdl[a[10:1]]});
    if (ill) check(m == 0 ? "r_edat0" : "r_edat1", {16'd0, rdat}, 32'd0);
  endtask

  initial begin
    logic [15:0] rdat;
    logic        err;
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.scb_rdy_i = 1'b1;
    #2;
    check("rst_outs", {bus.scb_ce_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o,
                       bus.m0_Data_o, bus.scb_Addr_o}, 32'd0);
    nxt();
    nxt();
    rst = 1'b0;

    // Single read
    preload(10'd2, 16'hBEEF);
    drive(0, 11'h004, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_issue", {bus.scb_ce_o, bus.scb_rd_o, 19'd0, bus.scb_Addr_o}, {2'b11, 19'd0, 11'h004});
    check("t1_noack", {31'd0, bus.m0_ack_o}, 32'd0);
    nxt();
    @(negedge clk);
    check("t1_ack", {bus.m0_ack_o, bus.m0_err_o, 14'd0, bus.m0_Data_o}, {2'b10, 14'd0, 16'hBEEF});
    nxt();
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Contention, both arbitration modes
    do_reset();
    drive(0, 11'h010, 16'h1111, 2'b11, 1'b0, 1'b1, 1'b1);
    drive(1, 11'h410, 16'h2222, 2'b11, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t2_ce", {31'd0, bus.scb_ce_o}, 32'd1);
      check("t2_order", {21'd0, bus.scb_Addr_o}, (c % 2 == 1) ? 32'h410 : 32'h010);
      check("t2_order_fix", {21'd0, bus_f.scb_Addr_o}, (c % 2 == 1) ? 32'h410 : 32'h010);
      if (c > 0) check("t2_acks", {30'd0, bus.m1_ack_o, bus.m0_ack_o},
                       ((c - 1) % 2 == 1) ? 32'd2 : 32'd1);
      nxt();
    end
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    nxt();

    // Byte write then read back
    preload(10'h201, 16'h1234);
    do_txn(1, 11'h402, 16'hA5FF, 2'b10, 1'b0, 1'b1, rdat, err);
    check("t3_werr", {31'd0, err}, 32'd0);
    do_txn(1, 11'h402, 16'h0000, 2'b11, 1'b1, 1'b0, rdat, err);
    check("t3_rdat", {16'd0, rdat}, 32'h0000A534);

    // Stall with a late competitor; last grant is m0 so a free tie would go to m1
    do_txn(0, 11'h006, '0, 2'b11, 1'b1, 1'b0, rdat, err);
    bus.scb_rdy_i = 1'b0;
    drive(0, 11'h008, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_hold", {bus.scb_ce_o, bus.scb_rd_o, 19'd0, bus.scb_Addr_o}, {2'b11, 19'd0, 11'h008});
      check("t4_noack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
      nxt();
      if (k == 0) drive(1, 11'h40A, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    end
    bus.scb_rdy_i = 1'b1;
    @(negedge clk);
    check("t4_rel", {21'd0, bus.scb_Addr_o}, 32'h008);
    nxt();
    @(negedge clk);
    check("t4_ack0", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd1);
    check("t4_next", {21'd0, bus.scb_Addr_o}, 32'h40A);
    nxt();
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_ack1", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd2);
    nxt();
    drive(1, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Illegal command from m1 wins the tie, then m0 is served
    do_txn(0, 11'h00C, '0, 2'b11, 1'b1, 1'b0, rdat, err);
    drive(1, 11'h40C, 16'h5555, 2'b11, 1'b1, 1'b1, 1'b1);
    drive(0, 11'h00E, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_noce", {31'd0, bus.scb_ce_o}, 32'd0);
    nxt();
    @(negedge clk);
    check("t5_err", {bus.m1_ack_o, bus.m1_err_o, 14'd0, bus.m1_Data_o}, {2'b11, 30'd0});
    check("t5_m0", {bus.scb_ce_o, 20'd0, bus.scb_Addr_o}, {1'b1, 20'd0, 11'h00E});
    nxt();
    drive(1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_ack0", {bus.m0_ack_o, bus.m0_err_o, 30'd0}, {2'b10, 30'd0});
    nxt();
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset while an ack is pending
    drive(0, 11'h004, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    nxt();
    check("t6_pre", {31'd0, bus.m0_ack_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async", {bus.scb_ce_o, bus.m0_ack_o, bus.m0_err_o, 13'd0, bus.m0_Data_o},
          32'd0);
    check("t6_addr", {21'd0, bus.scb_Addr_o}, 32'd0);
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t6_noack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
      nxt();
    end
    drive(0, 11'h020, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    drive(1, 11'h420, '0, 2'b11, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_tie", {21'd0, bus.scb_Addr_o}, 32'h020);
    nxt();
    drive(0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_m1", {21'd0, bus.scb_Addr_o}, 32'h420);
    nxt();
    drive(1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    nxt();

    // Randomized traffic; each master owns one bank so per-master ordering suffices
    for (int i = 0; i < 1024; i++) mdl[i] = mem[i];
    chk_legal = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) rand_txn(0);
        done0 = 1;
      end
      begin
        for (int i = 0; i < 60; i++) rand_txn(1);
        done1 = 1;
      end
      begin
        while (!(done0 && done1)) begin
          bus.scb_rdy_i = ($urandom_range(0, 3) != 0);
          nxt();
        end
        bus.scb_rdy_i = 1'b1;
      end
    join
    chk_legal = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0t exp=done", $time);
    $fatal(1, "timeout");
  end
endmodule
